// File: rtl/proc_pkg.sv
// Shared types for the proc_core register-file CPU: opcodes, FSM states, flag bit positions.
package proc_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FLAGS_W  = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_CMP  = 4'hB,
        OP_MUL  = 4'hC,
        OP_RSVD = 4'hD,
        OP_RSVE = 4'hE,
        OP_RSVF = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // eflags packing is {V,C,N,Z}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/proc_if.sv
// Instruction, status and debug-read port bundle between the sequencer and proc_core.
interface proc_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREGS  = 4
);
    localparam int unsigned REG_AW  = $clog2(NREGS);
    localparam int unsigned INSTR_W = 4 + 2 * REG_AW + DATA_W;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [3:0]         eflags;
    logic [REG_AW-1:0]  dbg_sel;
    logic [DATA_W-1:0]  dbg_data;
    logic               retired;
    logic               illegal;

    modport master (
        output instr, instr_valid, dbg_sel,
        input  instr_ready, eflags, dbg_data, retired, illegal
    );

    modport slave (
        input  instr, instr_valid, dbg_sel,
        output instr_ready, eflags, dbg_data, retired, illegal
    );
endinterface

// File: rtl/proc_alu.sv
// Single-cycle ALU: result, next flags and write/flag/illegal classification per opcode.
// With PROC_MUL_EN defined, opcode C is classified legal; the product itself comes from proc_core.
module proc_alu
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags_next,
    output logic              writes_rd,
    output logic              updates_flags,
    output logic              is_illegal
);
    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   add_ext;
    logic [DATA_W:0]   sub_ext;
    logic              carry;
    logic              ovf;

    always_comb begin
        addend        = (op == OP_ADDI) ? imm : b;
        add_ext       = {1'b0, a} + {1'b0, addend};
        sub_ext       = {1'b0, a} - {1'b0, b};
        result        = '0;
        carry         = 1'b0;
        ovf           = 1'b0;
        writes_rd     = 1'b0;
        updates_flags = 1'b0;
        is_illegal    = 1'b0;
        case (op)
            OP_NOP: ;
            OP_LDI: begin result = imm;   writes_rd = 1'b1; updates_flags = 1'b1; end
            OP_MOV: begin result = b;     writes_rd = 1'b1; updates_flags = 1'b1; end
            OP_AND: begin result = a & b; writes_rd = 1'b1; updates_flags = 1'b1; end
            OP_OR:  begin result = a | b; writes_rd = 1'b1; updates_flags = 1'b1; end
            OP_XOR: begin result = a ^ b; writes_rd = 1'b1; updates_flags = 1'b1; end
            OP_ADD, OP_ADDI: begin
                result        = add_ext[MSB:0];
                carry         = add_ext[DATA_W];
                ovf           = (a[MSB] == addend[MSB]) && (result[MSB] != a[MSB]);
                writes_rd     = 1'b1;
                updates_flags = 1'b1;
            end
            // top bit of the widened difference is the unsigned borrow
            OP_SUB, OP_CMP: begin
                result        = sub_ext[MSB:0];
                carry         = sub_ext[DATA_W];
                ovf           = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
                writes_rd     = (op == OP_SUB);
                updates_flags = 1'b1;
            end
            OP_SHL: begin
                result        = {a[MSB-1:0], 1'b0};
                carry         = a[MSB];
                writes_rd     = 1'b1;
                updates_flags = 1'b1;
            end
            OP_SHR: begin
                result        = {1'b0, a[MSB:1]};
                carry         = a[0];
                writes_rd     = 1'b1;
                updates_flags = 1'b1;
            end
`ifdef PROC_MUL_EN
            OP_MUL: begin writes_rd = 1'b1; updates_flags = 1'b1; end
`endif
            default: is_illegal = 1'b1;
        endcase
        flags_next         = '0;
        flags_next[FLAG_Z] = (result == '0);
        flags_next[FLAG_N] = result[MSB];
        flags_next[FLAG_C] = carry;
        flags_next[FLAG_V] = ovf;
    end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle register-file CPU core: IDLE -> EXEC -> WB, valid/ready instruction port, debug read.
// Define PROC_MUL_EN to make opcode C a shift-add multiply that holds EXEC for DATA_W cycles.
module proc_core
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREGS  = 4
) (
    input  logic   clk,
    input  logic   rst,
    proc_if.slave  bus
);
    localparam int unsigned REG_AW  = $clog2(NREGS);
    localparam int unsigned INSTR_W = 4 + 2 * REG_AW + DATA_W;

    state_e             state;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREGS];
    logic [DATA_W-1:0]  res_q;
    logic [3:0]         flags_q;
    logic               wr_q;
    logic               upd_q;
    logic               ready_q;
    logic               retired_q;
    logic               illegal_q;
    logic [3:0]         eflags_q;

    opcode_e            ir_op;
    logic [REG_AW-1:0]  ir_rd;
    logic [REG_AW-1:0]  ir_rs;
    logic [DATA_W-1:0]  ir_imm;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;

    logic [DATA_W-1:0]  alu_result;
    logic [3:0]         alu_flags;
    logic               alu_wr;
    logic               alu_upd;
    logic               alu_ill;

    assign ir_op  = opcode_e'(ir[INSTR_W-1 -: OPCODE_W]);
    assign ir_rd  = ir[DATA_W+2*REG_AW-1 -: REG_AW];
    assign ir_rs  = ir[DATA_W+REG_AW-1 -: REG_AW];
    assign ir_imm = ir[DATA_W-1:0];
    assign op_a   = regs[ir_rd];
    assign op_b   = regs[ir_rs];

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op            (ir_op),
        .a             (op_a),
        .b             (op_b),
        .imm           (ir_imm),
        .result        (alu_result),
        .flags_next    (alu_flags),
        .writes_rd     (alu_wr),
        .updates_flags (alu_upd),
        .is_illegal    (alu_ill)
    );

`ifdef PROC_MUL_EN
    localparam int unsigned STEP_W = $clog2(DATA_W);
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [STEP_W-1:0] step;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_next;
    logic [3:0]        mul_flags;

    // one partial product per EXEC cycle, multiplier bit selected by the step counter
    assign prod_next = prod + (op_a[step] ? (PROD_W'(op_b) << step) : '0);

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (prod_next[DATA_W-1:0] == '0);
        mul_flags[FLAG_N] = prod_next[DATA_W-1];
        mul_flags[FLAG_C] = |prod_next[PROD_W-1:DATA_W];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ir        <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            wr_q      <= 1'b0;
            upd_q     <= 1'b0;
            ready_q   <= 1'b1;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            eflags_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef PROC_MUL_EN
            step      <= '0;
            prod      <= '0;
`endif
        end else begin
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        ir      <= bus.instr;
                        ready_q <= 1'b0;
                        state   <= EXEC;
`ifdef PROC_MUL_EN
                        step    <= '0;
                        prod    <= '0;
`endif
                    end
                end
                EXEC: begin
`ifdef PROC_MUL_EN
                    if (ir_op == OP_MUL) begin
                        prod <= prod_next;
                        step <= step + STEP_W'(1);
                        if (step == STEP_W'(DATA_W - 1)) begin
                            res_q     <= prod_next[DATA_W-1:0];
                            flags_q   <= mul_flags;
                            wr_q      <= 1'b1;
                            upd_q     <= 1'b1;
                            retired_q <= 1'b1;
                            state     <= WB;
                        end
                    end else
`endif
                    begin
                        res_q     <= alu_result;
                        flags_q   <= alu_flags;
                        wr_q      <= alu_wr;
                        upd_q     <= alu_upd;
                        retired_q <= 1'b1;
                        illegal_q <= alu_ill;
                        state     <= WB;
                    end
                end
                WB: begin
                    if (wr_q)  regs[ir_rd] <= res_q;
                    if (upd_q) eflags_q    <= flags_q;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.retired     = retired_q;
    assign bus.illegal     = illegal_q;
    assign bus.eflags      = eflags_q;
    assign bus.dbg_data    = regs[bus.dbg_sel];

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: directed spot checks plus randomized traffic against an
// architectural model. Honors PROC_MUL_EN the same way as the RTL.
module tb_proc_core;
    localparam int unsigned W    = 4;
    localparam int unsigned NR   = 4;
    localparam int unsigned AW   = 2;
    localparam int unsigned IW   = 4 + 2 * AW + W;
    localparam int          MOD  = 16;
    localparam int          HALF = 8;
`ifdef PROC_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk;
    logic rst;

    proc_if #(.DATA_W(W), .NREGS(NR)) bus ();

    proc_core #(.DATA_W(W), .NREGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // architectural model: register values, flags, and a countdown of busy cycles
    int          m_regs [NR];
    logic [3:0]  m_flags;
    int          m_cnt;
    logic [IW-1:0] m_pend;

    function automatic logic [IW-1:0] mk(input int op, input int rd, input int rs, input int imm);
        return {4'(op), AW'(rd), AW'(rs), W'(imm)};
    endfunction

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    function automatic bit is_ill(input logic [IW-1:0] ins);
        int op;
        op = int'(ins[IW-1 -: 4]);
        return (op >= 13) || (op == 12 && !MUL_ON);
    endfunction

    function automatic int lat_of(input logic [IW-1:0] ins);
        return (MUL_ON && ins[IW-1 -: 4] == 4'hC) ? W + 1 : 2;
    endfunction

    task automatic apply(input logic [IW-1:0] ins);
        int op, rd, rs, imm, a, b, r, s, sv;
        bit c, v, wr, fl;
        op  = int'(ins[IW-1 -: 4]);
        rd  = int'(ins[W+2*AW-1 -: AW]);
        rs  = int'(ins[W+AW-1 -: AW]);
        imm = int'(ins[W-1:0]);
        a = m_regs[rd]; b = m_regs[rs];
        r = 0; c = 0; v = 0; wr = 0; fl = 0;
        case (op)
            1:  begin r = imm;   wr = 1; fl = 1; end
            2:  begin r = b;     wr = 1; fl = 1; end
            5:  begin r = a & b; wr = 1; fl = 1; end
            6:  begin r = a | b; wr = 1; fl = 1; end
            7:  begin r = a ^ b; wr = 1; fl = 1; end
            3, 8: begin
                if (op == 8) b = imm;
                s = a + b; r = s % MOD; c = (s >= MOD);
                sv = sgn(a) + sgn(b); v = (sv > HALF - 1) || (sv < -HALF);
                wr = 1; fl = 1;
            end
            4, 11: begin
                s = a - b; r = (s + MOD) % MOD; c = (a < b);
                sv = sgn(a) - sgn(b); v = (sv > HALF - 1) || (sv < -HALF);
                wr = (op == 4); fl = 1;
            end
            9:  begin r = (a * 2) % MOD; c = (a >= HALF); wr = 1; fl = 1; end
            10: begin r = a / 2;         c = (a % 2 == 1); wr = 1; fl = 1; end
            12: if (MUL_ON) begin
                s = a * b; r = s % MOD; c = (s >= MOD); wr = 1; fl = 1;
            end
            default: ;
        endcase
        if (wr) m_regs[rd] = r;
        if (fl) m_flags = {v, c, (r >= HALF), (r == 0)};
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, expv, $time);
        end
    endtask

    // advance one clock: model reacts at the rising edge, outputs compared at the falling edge
    task automatic tick();
        bit exp_ret;
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_flags = '0; m_pend = '0;
            for (int i = 0; i < NR; i++) m_regs[i] = 0;
        end else if (m_cnt == 0) begin
            if (bus.instr_valid) begin
                m_pend = bus.instr;
                m_cnt  = lat_of(bus.instr);
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) apply(m_pend);
        end
        @(negedge clk);
        exp_ret = (m_cnt == 1);
        chk("instr_ready", 32'(bus.instr_ready), 32'(m_cnt == 0));
        chk("retired",     32'(bus.retired),     32'(exp_ret));
        chk("illegal",     32'(bus.illegal),     32'(exp_ret && is_ill(m_pend)));
        chk("eflags",      32'(bus.eflags),      32'(m_flags));
        chk("dbg_data",    32'(bus.dbg_data),    32'(m_regs[bus.dbg_sel]));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (m_cnt != 0 && g < 20) begin tick(); g++; end
        if (g >= 20) chk("drain_timeout", 32'(g), 32'(0));
    endtask

    task automatic issue(input logic [IW-1:0] ins, output int lat, output logic ill);
        drain();
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        lat = 1;
        while (bus.retired !== 1'b1 && lat < 40) begin tick(); lat++; end
        ill = bus.illegal;
        drain();
    endtask

    task automatic peek(input string nm, input int sel, input int expv);
        bus.dbg_sel = AW'(sel);
        #1;
        chk(nm, 32'(bus.dbg_data), 32'(expv));
    endtask

    initial begin
        int   lat;
        logic ill;
        int   acc;

        rst = 1'b1;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.dbg_sel = '0;
        m_cnt = 0; m_flags = '0; m_pend = '0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_ready",  32'(bus.instr_ready), 32'd1);
        chk("reset_eflags", 32'(bus.eflags),      32'd0);

        issue(mk(1, 1, 0, 4'hD), lat, ill);
        chk("ldi_latency", 32'(lat), 32'd2);
        peek("ldi_r1", 1, 4'hD);
        chk("ldi_flags", 32'(bus.eflags), 32'b0010);

        issue(mk(1, 2, 0, 4'h4), lat, ill);
        issue(mk(3, 2, 1, 0), lat, ill);
        peek("add_r2", 2, 4'h1);
        chk("add_flags", 32'(bus.eflags), 32'b0100);

        issue(mk(1, 0, 0, 4'h7), lat, ill);
        issue(mk(8, 0, 0, 1), lat, ill);
        peek("addi_r0", 0, 4'h8);
        chk("addi_flags", 32'(bus.eflags), 32'b1010);

        issue(mk(11, 0, 0, 0), lat, ill);
        peek("cmp_r0", 0, 4'h8);
        chk("cmp_flags", 32'(bus.eflags), 32'b0001);

        issue(mk(14, 1, 2, 3), lat, ill);
        chk("ill_pulse", 32'(ill), 32'd1);
        peek("ill_r1", 1, 4'hD);
        chk("ill_flags", 32'(bus.eflags), 32'b0001);

        // back-to-back requests: exactly one accept per three cycles
        acc = 0;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.instr = mk($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
            if (bus.instr_ready) acc++;
            tick();
        end
        bus.instr_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd4);
        drain();

        // reset during EXEC of an ADD aborts it
        bus.instr = mk(3, 2, 1, 0);
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_no_retire", 32'(bus.retired), 32'd0);
        chk("rst_eflags",    32'(bus.eflags),  32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        peek("rst_r1", 1, 0);

        issue(mk(1, 1, 0, 3), lat, ill);
        issue(mk(1, 2, 0, 6), lat, ill);
        issue(mk(12, 1, 2, 0), lat, ill);
`ifdef PROC_MUL_EN
        chk("mul_latency", 32'(lat), 32'd5);
        peek("mul_r1", 1, 4'h2);
        chk("mul_flags", 32'(bus.eflags), 32'b0100);
`else
        chk("opc_illegal", 32'(ill), 32'd1);
        peek("opc_r1", 1, 4'h3);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr = IW'($urandom);
            bus.dbg_sel = AW'($urandom);
            tick();
        end
        rst = 1'b0;
        bus.instr_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
